sub_share_arbiter: RTL and testbench
====================================

// Module: sub_share_arbiter
// PURPOSE
//   Shares one external 10-bit combinational subtractor among N_REQ requesters
//   (head-vs-food, head-vs-wall, head-vs-segment distance checks in the snake core).
//   Round-robin arbitration, valid/ready request handshake, registered one-hot response.
//   Drives the subtractor's A/B operands and captures its D output; does no subtraction itself.
// PARAMETERS
//   N_REQ  4   number of requesters (2..8)
//   WIDTH  10  operand/result width; must equal the shared subtractor width
// PORTS
//   clk         in   1            rising-edge clock
//   rst_n       in   1            asynchronous active-low reset
//   req_valid   in   N_REQ        per-requester request; held with operands until req_ready
//   req_a       in   N_REQ*WIDTH  minuend, requester i at [i*WIDTH +: WIDTH]
//   req_b       in   N_REQ*WIDTH  subtrahend, same packing
//   req_ready   out  N_REQ        one-hot accept strobe (combinational, IDLE only)
//   sub_a       out  WIDTH        operand A to shared subtractor
//   sub_b       out  WIDTH        operand B to shared subtractor
//   sub_d       in   WIDTH        subtractor result, expected (sub_a - sub_b) mod 2^WIDTH
//   rsp_valid   out  N_REQ        one-hot, one-cycle result strobe to owning requester
//   rsp_diff    out  WIDTH        captured difference; valid with rsp_valid, held after
//   rsp_zero    out  1            rsp_diff == 0; valid with rsp_valid
//   busy        out  1            high in EXEC and DONE
// BEHAVIOUR
//   FSM: IDLE -> EXEC -> DONE -> IDLE; one operation per 3 cycles, no backpressure on rsp.
//   IDLE: grant g = first i with req_valid[i], searching ptr, ptr+1, ... mod N_REQ.
//     req_ready[g]=1 same cycle; on that edge latch req_a[g], req_b[g], g; -> EXEC.
//     No req_valid: req_ready=0, stay IDLE.
//   EXEC: sub_a/sub_b = latched operands; at end of cycle rsp_diff <= sub_d,
//     rsp_zero <= (sub_d==0); -> DONE.
//   DONE: rsp_valid[g]=1 for exactly this cycle; ptr <= (g+1) mod N_REQ; -> IDLE.
//   Latency: accept at cycle t, rsp_valid at t+2; next accept earliest t+3.
//   sub_a/sub_b = 0 outside EXEC. req_ready = 0 outside IDLE.
//   Arithmetic: modulo 2^WIDTH, no borrow output; A<B wraps (5-10 -> 1019).
//   Requester dropping req_valid before req_ready: protocol violation, no defined outcome.
//   New req_valid from the owning requester during DONE is not seen until IDLE.
//   Reset (async, any state): state=IDLE, ptr=0, req_ready=0, rsp_valid=0,
//     rsp_diff=0, rsp_zero=0, sub_a=sub_b=0, busy=0; in-flight op dropped, no rsp.
//   Only one-hot values ever appear on req_ready and rsp_valid.
// TESTING (bench models sub_d = (sub_a - sub_b) mod 1024, combinational)
//   1 Port 2 only, A=700 B=200 -> req_ready=4'b0100 at t, rsp_valid=4'b0100 at t+2,
//     rsp_diff=500, rsp_zero=0, busy high t+1..t+2.
//   2 Port 0, A=5 B=10 -> rsp_diff=1019, rsp_zero=0; port 1, A=300 B=300 -> rsp_diff=0,
//     rsp_zero=1.
//   3 All four req_valid held high from reset -> grants 0,1,2,3,0 at cycles
//     t, t+3, t+6, t+9, t+12; each rsp carries its own requester's difference.
//   4 After a grant to 2, assert ports 1 and 3 together -> 3 granted before 1.
//   5 rst_n low during EXEC -> all outputs 0 immediately, no rsp_valid for the
//     dropped op; first grant after release follows ptr=0 order.
//   6 Operands on a non-granted port changed during EXEC -> rsp_diff unaffected.

Source files
------------

// File: rtl/sub_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational subtractor
// among N_REQ requesters; one operation every three cycles, one-hot response.
module sub_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]         sub_a,
    output logic [WIDTH-1:0]         sub_b,
    input  logic [WIDTH-1:0]         sub_d,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]         rsp_diff,
    output logic                     rsp_zero,
    output logic                     busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     ptr_reg;
    logic [PW-1:0]     owner_reg;
    logic [WIDTH-1:0]  a_reg, b_reg, diff_reg;
    logic              zero_reg;

    logic              grant_found;
    logic [PW-1:0]     grant_idx;
    logic [PW:0]       scan_sum;
    logic [PW-1:0]     scan_idx;
    logic [N_REQ-1:0]  grant_onehot;
    logic [N_REQ-1:0]  owner_onehot;
    logic [WIDTH-1:0]  a_arr [N_REQ];
    logic [WIDTH-1:0]  b_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
            assign a_arr[gi]        = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi]        = req_b[gi*WIDTH +: WIDTH];
            assign grant_onehot[gi] = grant_found && (grant_idx == PW'(gi));
            assign owner_onehot[gi] = (owner_reg == PW'(gi));
        end
    endgenerate

    // Scan from the far end back toward ptr so the nearest valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, ptr_reg} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(N_REQ))
                scan_sum = scan_sum - (PW+1)'(N_REQ);
            scan_idx = scan_sum[PW-1:0];
            if (req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_found) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // req_ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        req_ready = '0;
        sub_a     = '0;
        sub_b     = '0;
        rsp_valid = '0;
        busy      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rst_n)
                    req_ready = grant_onehot;
            end
            EXEC: begin
                sub_a = a_reg;
                sub_b = b_reg;
                busy  = 1'b1;
            end
            DONE: begin
                rsp_valid = owner_onehot;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg   <= '0;
            owner_reg <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            diff_reg  <= '0;
            zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        owner_reg <= grant_idx;
                        a_reg     <= a_arr[grant_idx];
                        b_reg     <= b_arr[grant_idx];
                    end
                end
                EXEC: begin
                    diff_reg <= sub_d;
                    zero_reg <= (sub_d == '0);
                end
                DONE: begin
                    ptr_reg <= (owner_reg == PW'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_diff = diff_reg;
    assign rsp_zero = zero_reg;

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Bench for sub_share_arbiter: table of single operations, directed corner
// sequences, then random traffic against a round-robin reference model.
module tb_sub_share_arbiter;

    localparam int N = 4;
    localparam int W = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a, req_b;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     sub_a, sub_b, sub_d;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_diff;
    logic             rsp_zero;
    logic             busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    sub_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .sub_a(sub_a), .sub_b(sub_b), .sub_d(sub_d),
        .rsp_valid(rsp_valid), .rsp_diff(rsp_diff), .rsp_zero(rsp_zero), .busy(busy)
    );

    // external shared subtractor
    assign sub_d = sub_a - sub_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input int a, input int b);
        req_a[p*W +: W] = a[W-1:0];
        req_b[p*W +: W] = b[W-1:0];
    endtask

    task automatic wait_grant(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_grant_seen"}, 32'(req_ready != '0), 32'd1);
    endtask

    task automatic run_single(input string nm, input int p, input int a, input int b,
                              input int diff, input bit zero);
        tick();
        req_valid = N'(1 << p);
        set_req(p, a, b);
        wait_grant(nm);
        chk({nm, "_ready"}, 32'(req_ready), 32'(1 << p));
        chk({nm, "_busy_t"}, 32'(busy), 32'd0);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk({nm, "_busy_t1"}, 32'(busy), 32'd1);
        chk({nm, "_sub_a"}, 32'(sub_a), 32'(a));
        chk({nm, "_sub_b"}, 32'(sub_b), 32'(b));
        chk({nm, "_rsp_early"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'(1 << p));
        chk({nm, "_diff"}, 32'(rsp_diff), 32'(diff));
        chk({nm, "_zero"}, 32'(rsp_zero), 32'(zero));
        chk({nm, "_busy_t2"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({nm, "_rsp_off"}, 32'(rsp_valid), 32'd0);
        chk({nm, "_busy_t3"}, 32'(busy), 32'd0);
        chk({nm, "_diff_held"}, 32'(rsp_diff), 32'(diff));
    endtask

    typedef struct {
        int p;
        int a;
        int b;
        int diff;
        bit zero;
    } vec_t;

    typedef struct {
        int due;
        int port;
        int diff;
    } exp_t;

    initial begin
        vec_t tbl[4];
        int   ta[4], tb_b[4], texp[4];
        int   prev;
        exp_t q[$];
        bit   hold[N], acc[N];
        int   opa[N], opb[N];
        int   mptr, cool, g, idx;
        bit   found, exp_busy;

        tbl[0] = '{p: 2, a: 700, b: 200,  diff: 500,  zero: 1'b0};
        tbl[1] = '{p: 0, a: 5,   b: 10,   diff: 1019, zero: 1'b0};
        tbl[2] = '{p: 1, a: 300, b: 300,  diff: 0,    zero: 1'b1};
        tbl[3] = '{p: 3, a: 0,   b: 1023, diff: 1,    zero: 1'b0};

        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        #3;
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sub_a", 32'(sub_a), 32'd0);
        chk("reset_diff", 32'(rsp_diff), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 4; i++)
            run_single($sformatf("vec%0d", i), tbl[i].p, tbl[i].a, tbl[i].b, tbl[i].diff, tbl[i].zero);

        // all four held high from reset: grants 0,1,2,3,0 every 3 cycles
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            ta[i]   = 100 * (i + 1) + 7;
            tb_b[i] = 50 + 3 * i;
        end
        ta[3] = 20;
        tb_b[3] = 900;
        for (int i = 0; i < N; i++) begin
            set_req(i, ta[i], tb_b[i]);
            texp[i] = (ta[i] - tb_b[i]) & 1023;
        end
        req_valid = '1;
        tick();
        tick();
        rst_n = 1'b1;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant($sformatf("rr%0d", k));
            chk($sformatf("rr%0d_grant", k), 32'(req_ready), 32'(1 << (k % N)));
            if (k > 0)
                chk($sformatf("rr%0d_spacing", k), 32'(cyc - prev), 32'd3);
            prev = cyc;
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("rr%0d_rsp", k), 32'(rsp_valid), 32'(1 << (k % N)));
            chk($sformatf("rr%0d_diff", k), 32'(rsp_diff), 32'(texp[k % N]));
        end
        tick();
        req_valid = '0;

        // after a grant to 2, ports 1 and 3 together: 3 wins first
        run_single("pre4", 2, 400, 123, 277, 1'b0);
        tick();
        set_req(1, 50, 60);
        set_req(3, 999, 1);
        req_valid = 4'b1010;
        wait_grant("t4a");
        chk("t4_first_is_3", 32'(req_ready), 32'd8);
        tick();
        req_valid = 4'b0010;
        set_req(3, 0, 0);
        set_req(0, 1, 555);
        set_req(2, 1023, 17);
        @(negedge clk);
        chk("t6_sub_a", 32'(sub_a), 32'd999);
        @(negedge clk);
        chk("t6_rsp", 32'(rsp_valid), 32'd8);
        chk("t6_diff_stable", 32'(rsp_diff), 32'd998);
        wait_grant("t4b");
        chk("t4_second_is_1", 32'(req_ready), 32'd2);
        tick();
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("t4_rsp1", 32'(rsp_valid), 32'd2);
        chk("t4_diff1", 32'(rsp_diff), 32'd1014);

        // reset during EXEC drops the op and restores ptr=0
        run_single("pre5", 2, 900, 100, 800, 1'b0);
        tick();
        set_req(3, 10, 3);
        req_valid = 4'b1000;
        wait_grant("t5");
        chk("t5_grant", 32'(req_ready), 32'd8);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_sub_a", 32'(sub_a), 32'd0);
        chk("t5_sub_b", 32'(sub_b), 32'd0);
        chk("t5_rsp", 32'(rsp_valid), 32'd0);
        chk("t5_diff", 32'(rsp_diff), 32'd0);
        chk("t5_zero", 32'(rsp_zero), 32'd0);
        chk("t5_ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t5_rsp_hold", 32'(rsp_valid), 32'd0);
            chk("t5_ready_hold", 32'(req_ready), 32'd0);
        end
        tick();
        set_req(1, 77, 7);
        req_valid = 4'b1010;
        rst_n = 1'b1;
        wait_grant("t5b");
        chk("t5_ptr0_grant", 32'(req_ready), 32'd2);
        tick();
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_rsp1", 32'(rsp_valid), 32'd2);
        chk("t5_diff1", 32'(rsp_diff), 32'd70);

        // random traffic against the round-robin model
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mptr = 0;
        cool = 0;
        for (int i = 0; i < N; i++) begin
            hold[i] = 1'b0;
            acc[i]  = 1'b0;
            opa[i]  = 0;
            opb[i]  = 0;
        end
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    hold[i] = 1'b0;
                    acc[i]  = 1'b0;
                end
                if (!hold[i] && c < 380 && $urandom_range(0, 2) == 0) begin
                    hold[i] = 1'b1;
                    opa[i]  = int'($urandom_range(0, 1023));
                    opb[i]  = ($urandom_range(0, 7) == 0) ? opa[i] : int'($urandom_range(0, 1023));
                    set_req(i, opa[i], opb[i]);
                end
                req_valid[i] = hold[i];
            end
            @(negedge clk);
            exp_busy = (cool > 0);
            found = 1'b0;
            g = 0;
            if (cool > 0) begin
                cool--;
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = (mptr + k) % N;
                    if (!found && hold[idx]) begin
                        found = 1'b1;
                        g = idx;
                    end
                end
            end
            if (found) begin
                q.push_back('{due: c + 2, port: g, diff: (opa[g] - opb[g]) & 1023});
                cool = 2;
                mptr = (g + 1) % N;
                acc[g] = 1'b1;
                chk("rand_ready", 32'(req_ready), 32'(1 << g));
            end else begin
                chk("rand_ready_idle", 32'(req_ready), 32'd0);
            end
            chk("rand_busy", 32'(busy), 32'(exp_busy));
            if (q.size() > 0 && q[0].due == c) begin
                chk("rand_rsp", 32'(rsp_valid), 32'(1 << q[0].port));
                chk("rand_diff", 32'(rsp_diff), 32'(q[0].diff));
                chk("rand_zero", 32'(rsp_zero), 32'(q[0].diff == 0));
                void'(q.pop_front());
            end else begin
                chk("rand_rsp_none", 32'(rsp_valid), 32'd0);
            end
        end
        chk("rand_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
